// File: rtl/seq_ctrl_pkg.sv
// Shared definitions for the instruction sequencer: FSM states, opcodes,
// instruction field positions, branch conditions and the branch target table.
package definitions;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_EXEC, S_MEM, S_HALT, S_FAULT
  } seq_state_t;

  localparam logic [2:0] kCMP   = 3'd6;
  localparam logic [1:0] kMOVE  = 2'd0;
  localparam logic [1:0] kLOAD  = 2'd1;
  localparam logic [1:0] kFLAG  = 2'd2;
  localparam logic [1:0] kSTORE = 2'd3;
  localparam logic [8:0] kHALT  = 9'h1FF;

  localparam int kCLASS_BIT = 8;
  localparam int kAOP_LSB   = 5;
  localparam int kRA_LSB    = 2;
  localparam int kRB_LSB    = 0;
  localparam int kDOP_LSB   = 6;
  localparam int kRD_LSB    = 3;
  localparam int kRS_LSB    = 0;

  localparam logic [2:0] kC_ALWAYS = 3'd0;
  localparam logic [2:0] kC_Z      = 3'd1;
  localparam logic [2:0] kC_NZ     = 3'd2;
  localparam logic [2:0] kC_EQ     = 3'd3;
  localparam logic [2:0] kC_NEQ    = 3'd4;
  localparam logic [2:0] kC_BEVEN  = 3'd5;
  localparam logic [2:0] kC_PARITY = 3'd6;

  // Flag register bit positions
  localparam int kFLG_Z      = 0;
  localparam int kFLG_BEVEN  = 1;
  localparam int kFLG_PARITY = 2;
  localparam int kFLG_EQ     = 3;

  localparam logic [15:0] kBRANCH_LUT [0:7] = '{
    16'd0, 16'd20, 16'd40, 16'd60, 16'd100, 16'd200, 16'd300, 16'd1023
  };

  function automatic logic cond_taken(input logic [2:0] c, input logic [3:0] f);
    case (c)
      kC_ALWAYS: cond_taken = 1'b1;
      kC_Z:      cond_taken = f[kFLG_Z];
      kC_NZ:     cond_taken = !f[kFLG_Z];
      kC_EQ:     cond_taken = f[kFLG_EQ];
      kC_NEQ:    cond_taken = !f[kFLG_EQ];
      kC_BEVEN:  cond_taken = f[kFLG_BEVEN];
      kC_PARITY: cond_taken = f[kFLG_PARITY];
      default:   cond_taken = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/seq_ctrl_branch_lut.sv
// Combinational branch target table, indexed by the rs field of a FLAG instruction.
module branch_lut
  import definitions::*;
#(
  parameter int PC_W = 10
) (
  input  logic [2:0]      idx,
  output logic [PC_W-1:0] target
);

  always_comb target = kBRANCH_LUT[idx][PC_W-1:0];

endmodule

// File: rtl/seq_ctrl.sv
// Instruction sequencer/decoder for the 8-bit datapath.
// Optional memory-ack timeout with FAULT state: define SEQ_MEM_TIMEOUT_EN.
module seq_ctrl
  import definitions::*;
#(
  parameter int PC_W   = 10,
  parameter int TO_CYC = 16
) (
  input  logic            CLK,
  input  logic            Reset,
  input  logic            start,
  output logic [PC_W-1:0] instr_addr,
  input  logic [8:0]      instr_data,
  output logic [2:0]      ALU_op_code,
  output logic [1:0]      Data_op_code,
  output logic            Data_signifier,
  input  logic            ZERO,
  input  logic            BEVEN,
  input  logic            PARITY,
  input  logic            EQUAL,
  output logic [2:0]      rf_raddr_a,
  output logic [2:0]      rf_raddr_b,
  output logic [2:0]      rf_waddr,
  output logic            rf_we,
  output logic            wb_sel,
  output logic            mem_req,
  output logic            mem_we,
  input  logic            mem_ack,
  output logic            done,
  output logic            fault
);

  seq_state_t      state, state_nx;
  logic [PC_W-1:0] pc, pc_nx, pc_inc, lut_target;
  logic [8:0]      ir;
  logic [3:0]      flags;
  logic            flags_ld;

  logic            is_data, is_halt, taken;
  logic [2:0]      aop, ra, rb, rd, rs;
  logic [1:0]      dop;

  assign is_data = ir[kCLASS_BIT];
  assign aop     = ir[kAOP_LSB +: 3];
  assign ra      = ir[kRA_LSB +: 3];
  assign rb      = {1'b0, ir[kRB_LSB +: 2]};
  assign dop     = ir[kDOP_LSB +: 2];
  assign rd      = ir[kRD_LSB +: 3];
  assign rs      = ir[kRS_LSB +: 3];
  assign is_halt = (ir == kHALT);
  assign taken   = cond_taken(rd, flags);
  assign pc_inc  = pc + PC_W'(1);

  assign instr_addr = pc;

  branch_lut #(.PC_W(PC_W)) u_branch_lut (
    .idx    (rs),
    .target (lut_target)
  );

`ifdef SEQ_MEM_TIMEOUT_EN
  localparam int TO_W = $clog2(TO_CYC + 1);
  logic [TO_W-1:0] to_cnt;

  // Counts consecutive MEM cycles; cleared whenever the FSM is elsewhere
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset)               to_cnt <= '0;
    else if (state != S_MEM) to_cnt <= '0;
    else                     to_cnt <= to_cnt + TO_W'(1);
  end
`else
  logic unused_to;
  assign unused_to = (TO_CYC > 0);
`endif

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state <= S_IDLE;
      pc    <= '0;
      ir    <= '0;
      flags <= '0;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
      if (state == S_FETCH) ir <= instr_data;
      if (flags_ld) begin
        flags[kFLG_Z]      <= ZERO;
        flags[kFLG_BEVEN]  <= BEVEN;
        flags[kFLG_PARITY] <= PARITY;
        flags[kFLG_EQ]     <= EQUAL;
      end
    end
  end

  always_comb begin
    state_nx       = state;
    pc_nx          = pc;
    flags_ld       = 1'b0;
    ALU_op_code    = '0;
    Data_op_code   = '0;
    Data_signifier = 1'b0;
    rf_raddr_a     = '0;
    rf_raddr_b     = '0;
    rf_waddr       = '0;
    rf_we          = 1'b0;
    wb_sel         = 1'b0;
    mem_req        = 1'b0;
    mem_we         = 1'b0;
    done           = 1'b0;
    fault          = 1'b0;

    // Decoded datapath fields are only exposed while an instruction is live
    if (state == S_EXEC || state == S_MEM) begin
      Data_signifier = is_data;
      if (is_data) begin
        Data_op_code = dop;
        rf_raddr_a   = (dop == kSTORE) ? rd : rs;
        rf_raddr_b   = (dop == kSTORE) ? rs : rd;
        rf_waddr     = rd;
      end else begin
        ALU_op_code = aop;
        rf_raddr_a  = ra;
        rf_raddr_b  = rb;
        rf_waddr    = ra;
      end
    end

    case (state)
      S_IDLE: begin
        if (start) begin
          state_nx = S_FETCH;
          pc_nx    = '0;
        end
      end
      S_FETCH: state_nx = S_EXEC;
      S_EXEC: begin
        if (!is_data) begin
          flags_ld = 1'b1;
          rf_we    = (aop != kCMP);
          pc_nx    = pc_inc;
          state_nx = S_FETCH;
        end else if (is_halt) begin
          state_nx = S_HALT;
        end else begin
          case (dop)
            kMOVE: begin
              rf_we    = 1'b1;
              pc_nx    = pc_inc;
              state_nx = S_FETCH;
            end
            kFLAG: begin
              pc_nx    = taken ? lut_target : pc_inc;
              state_nx = S_FETCH;
            end
            default: state_nx = S_MEM;
          endcase
        end
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = (dop == kSTORE);
        if (mem_ack) begin
          rf_we    = (dop == kLOAD);
          wb_sel   = (dop == kLOAD);
          pc_nx    = pc_inc;
          state_nx = S_FETCH;
        end
`ifdef SEQ_MEM_TIMEOUT_EN
        else if (to_cnt == TO_W'(TO_CYC - 1)) begin
          state_nx = S_FAULT;
        end
`endif
      end
      S_HALT: begin
        done = 1'b1;
        if (start) begin
          state_nx = S_FETCH;
          pc_nx    = '0;
        end
      end
`ifdef SEQ_MEM_TIMEOUT_EN
      S_FAULT: fault = 1'b1;
`endif
      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_seq_ctrl.sv
// Bench for seq_ctrl: directed decode table, multi-cycle corner sequences and
// a randomized program checked against an instruction-level reference model.
module tb_seq_ctrl;

  localparam int PC_W = 10;
  localparam int ROM_N = 1 << PC_W;

  logic            CLK = 1'b0;
  logic            Reset, start, ZERO, BEVEN, PARITY, EQUAL, mem_ack;
  logic [PC_W-1:0] instr_addr;
  logic [8:0]      instr_data;
  logic [2:0]      ALU_op_code, rf_raddr_a, rf_raddr_b, rf_waddr;
  logic [1:0]      Data_op_code;
  logic            Data_signifier, rf_we, wb_sel, mem_req, mem_we, done, fault;

  logic [8:0] rom [0:ROM_N-1];
  assign instr_data = rom[instr_addr];

  always #5 CLK = ~CLK;

  seq_ctrl #(.PC_W(PC_W), .TO_CYC(16)) dut (
    .CLK(CLK), .Reset(Reset), .start(start),
    .instr_addr(instr_addr), .instr_data(instr_data),
    .ALU_op_code(ALU_op_code), .Data_op_code(Data_op_code),
    .Data_signifier(Data_signifier),
    .ZERO(ZERO), .BEVEN(BEVEN), .PARITY(PARITY), .EQUAL(EQUAL),
    .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b), .rf_waddr(rf_waddr),
    .rf_we(rf_we), .wb_sel(wb_sel), .mem_req(mem_req), .mem_we(mem_we),
    .mem_ack(mem_ack), .done(done), .fault(fault)
  );

  int total = 0;
  int bad   = 0;
  int lut_m [8] = '{0, 20, 40, 60, 100, 200, 300, 1023};

  typedef struct {
    logic [8:0] instr;
    logic [2:0] alu;
    logic [1:0] dop;
    logic       sig;
    logic [2:0] ra, rb, wa;
    logic       we;
    logic [9:0] npc;
  } vec_t;
  vec_t vt [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [8:0] enc_a(input int op, input int ra, input int rb);
    return {1'b0, 3'(op), 3'(ra), 2'(rb)};
  endfunction

  function automatic logic [8:0] enc_d(input int dop, input int rd, input int rs);
    return {1'b1, 2'(dop), 3'(rd), 3'(rs)};
  endfunction

  function automatic logic [31:0] all_outs();
    return 32'({instr_addr, ALU_op_code, Data_op_code, Data_signifier, rf_raddr_a,
                rf_raddr_b, rf_waddr, rf_we, wb_sel, mem_req, mem_we, done, fault});
  endfunction

  function automatic bit m_taken(input int c, input bit z, input bit ev, input bit par, input bit eq);
    case (c)
      0: return 1'b1;
      1: return z;
      2: return !z;
      3: return eq;
      4: return !eq;
      5: return ev;
      6: return par;
      default: return 1'b0;
    endcase
  endfunction

  task automatic do_reset();
    Reset = 1'b1; start = 1'b0; mem_ack = 1'b0;
    {ZERO, BEVEN, PARITY, EQUAL} = 4'b0;
    @(negedge CLK); @(negedge CLK);
    Reset = 1'b0;
    @(negedge CLK);
  endtask

  // Leaves the bench at the negedge inside the first FETCH cycle
  task automatic pulse_start();
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
  endtask

  task automatic run_table();
    for (int i = 0; i < 8; i++) begin
      do_reset();
      rom[0] = vt[i].instr;
      pulse_start();
      chk($sformatf("tbl%0d_fetch_pc", i), 32'(instr_addr), 32'd0);
      @(negedge CLK);
      chk($sformatf("tbl%0d_exec", i),
          32'({ALU_op_code, Data_op_code, Data_signifier, rf_raddr_a, rf_raddr_b, rf_waddr, rf_we}),
          32'({vt[i].alu, vt[i].dop, vt[i].sig, vt[i].ra, vt[i].rb, vt[i].wa, vt[i].we}));
      @(negedge CLK);
      chk($sformatf("tbl%0d_next_pc", i), 32'(instr_addr), 32'(vt[i].npc));
    end
  endtask

  task automatic seq_load();
    int req_cnt;
    do_reset();
    rom[0] = enc_d(1, 3, 5);
    pulse_start();
    @(negedge CLK);
    chk("load_exec_we", 32'(rf_we), 32'd0);
    req_cnt = 0;
    for (int k = 0; k <= 4; k++) begin
      @(negedge CLK);
      mem_ack = (k == 4);
      #1;
      if (mem_req) req_cnt++;
      chk($sformatf("load_mem%0d_we_wb_mwe", k), 32'({rf_we, wb_sel, mem_we}),
          (k == 4) ? 32'b110 : 32'b000);
      if (k == 0) chk("load_addr", 32'({rf_raddr_a, rf_waddr}), 32'({3'd5, 3'd3}));
    end
    @(negedge CLK);
    mem_ack = 1'b0;
    chk("load_req_cycles", 32'(req_cnt), 32'd5);
    chk("load_next_pc", 32'(instr_addr), 32'd1);
    chk("load_req_low", 32'(mem_req), 32'd0);
  endtask

  task automatic seq_branch(input bit eq);
    do_reset();
    rom[0] = enc_a(6, 1, 1);
    rom[1] = enc_d(2, 3, 2);
    EQUAL = eq;
    pulse_start();
    @(negedge CLK);
    chk($sformatf("cmp_we_eq%0d", eq), 32'(rf_we), 32'd0);
    @(negedge CLK);
    EQUAL = !eq;
    @(negedge CLK);
    @(negedge CLK);
    chk($sformatf("branch_pc_eq%0d", eq), 32'(instr_addr), eq ? 32'd40 : 32'd2);
  endtask

  task automatic seq_halt();
    do_reset();
    for (int i = 0; i < 7; i++) rom[i] = enc_a(0, 1, 2);
    rom[7] = 9'h1FF;
    pulse_start();
    for (int i = 0; i < 40 && !done; i++) @(negedge CLK);
    chk("halt_done", 32'(done), 32'd1);
    chk("halt_pc", 32'(instr_addr), 32'd7);
    repeat (3) @(negedge CLK);
    chk("halt_frozen", 32'({done, instr_addr}), 32'({1'b1, 10'd7}));
    pulse_start();
    chk("halt_restart", 32'({done, instr_addr}), 32'd0);
  endtask

  task automatic seq_reset_mem();
    do_reset();
    rom[0] = enc_d(3, 1, 2);
    pulse_start();
    @(negedge CLK);
    @(negedge CLK);
    chk("store_req_we", 32'({mem_req, mem_we}), 32'b11);
    #1 Reset = 1'b1;
    #1;
    chk("async_req_drop", 32'(mem_req), 32'd0);
    chk("async_all_zero", all_outs(), 32'd0);
    @(negedge CLK);
    Reset = 1'b0;
    repeat (2) @(negedge CLK);
    chk("post_reset_idle", all_outs(), 32'd0);
  endtask

`ifdef SEQ_MEM_TIMEOUT_EN
  task automatic seq_timeout();
    int req_cnt;
    do_reset();
    rom[0] = enc_d(1, 0, 0);
    pulse_start();
    @(negedge CLK);
    req_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge CLK);
      if (mem_req) req_cnt++;
    end
    chk("to_req_cycles", 32'(req_cnt), 32'd16);
    @(negedge CLK);
    chk("to_fault", 32'({mem_req, fault}), 32'b01);
    pulse_start();
    @(negedge CLK);
    chk("to_start_ignored", 32'({fault, instr_addr}), 32'({1'b1, 10'd0}));
  endtask
`endif

  task automatic run_random();
    int mpc, waits, dop, rd, rs;
    bit mz, mev, mpar, meq, ld;
    logic [8:0] w;
    do_reset();
    for (int i = 0; i < ROM_N; i++) rom[i] = 9'($urandom);
    rom[300] = 9'h1FF;
    pulse_start();
    mpc = 0;
    {mz, mev, mpar, meq} = 4'b0;
    for (int n = 0; n < 400; n++) begin
      chk("rnd_fetch_pc", 32'(instr_addr), 32'(mpc));
      w = rom[mpc];
      {ZERO, BEVEN, PARITY, EQUAL} = 4'($urandom);
      @(negedge CLK);
      if (!w[8]) begin
        chk("rnd_arith_we", 32'({rf_we, rf_waddr}), 32'({w[7:5] != 3'd6, w[4:2]}));
        {mz, mev, mpar, meq} = {ZERO, BEVEN, PARITY, EQUAL};
        mpc = (mpc + 1) % ROM_N;
        @(negedge CLK);
      end else if (w == 9'h1FF) begin
        @(negedge CLK);
        chk("rnd_halt", 32'({done, instr_addr}), 32'({1'b1, 10'(mpc)}));
        pulse_start();
        mpc = 0;
      end else begin
        dop = int'(w[7:6]); rd = int'(w[5:3]); rs = int'(w[2:0]);
        if (dop == 0) begin
          chk("rnd_move_we", 32'({rf_we, rf_waddr}), 32'({1'b1, 3'(rd)}));
          mpc = (mpc + 1) % ROM_N;
          @(negedge CLK);
        end else if (dop == 2) begin
          chk("rnd_branch_we", 32'(rf_we), 32'd0);
          mpc = m_taken(rd, mz, mev, mpar, meq) ? lut_m[rs] : (mpc + 1) % ROM_N;
          @(negedge CLK);
        end else begin
          ld = (dop == 1);
          chk("rnd_mem_exec_we", 32'(rf_we), 32'd0);
          waits = int'($urandom_range(0, 3));
          for (int k = 0; k <= waits; k++) begin
            @(negedge CLK);
            mem_ack = (k == waits);
            #1;
            chk("rnd_mem", 32'({mem_req, mem_we, rf_we, wb_sel}),
                32'({1'b1, !ld, (k == waits) && ld, (k == waits) && ld}));
          end
          @(negedge CLK);
          mem_ack = 1'b0;
          mpc = (mpc + 1) % ROM_N;
        end
      end
    end
  endtask

  initial begin
    Reset = 1'b1; start = 1'b0; mem_ack = 1'b0;
    {ZERO, BEVEN, PARITY, EQUAL} = 4'b0;
    for (int i = 0; i < ROM_N; i++) rom[i] = 9'h0;

    vt[0] = '{enc_a(0, 1, 2), 3'd0, 2'd0, 1'b0, 3'd1, 3'd2, 3'd1, 1'b1, 10'd1};
    vt[1] = '{enc_a(6, 3, 1), 3'd6, 2'd0, 1'b0, 3'd3, 3'd1, 3'd3, 1'b0, 10'd1};
    vt[2] = '{enc_a(7, 7, 3), 3'd7, 2'd0, 1'b0, 3'd7, 3'd3, 3'd7, 1'b1, 10'd1};
    vt[3] = '{enc_d(0, 4, 6), 3'd0, 2'd0, 1'b1, 3'd6, 3'd4, 3'd4, 1'b1, 10'd1};
    vt[4] = '{enc_d(2, 0, 2), 3'd0, 2'd2, 1'b1, 3'd2, 3'd0, 3'd0, 1'b0, 10'd40};
    vt[5] = '{enc_d(2, 1, 2), 3'd0, 2'd2, 1'b1, 3'd2, 3'd1, 3'd1, 1'b0, 10'd1};
    vt[6] = '{enc_d(2, 7, 7), 3'd0, 2'd2, 1'b1, 3'd7, 3'd7, 3'd7, 1'b0, 10'd1};
    vt[7] = '{enc_d(2, 2, 3), 3'd0, 2'd2, 1'b1, 3'd3, 3'd2, 3'd2, 1'b0, 10'd60};

    do_reset();
    chk("reset_outputs", all_outs(), 32'd0);
    start = 1'b0;
    repeat (2) @(negedge CLK);
    chk("idle_no_start", all_outs(), 32'd0);

    run_table();
    seq_load();
    seq_branch(1'b1);
    seq_branch(1'b0);
    seq_halt();
    seq_reset_mem();
`ifdef SEQ_MEM_TIMEOUT_EN
    seq_timeout();
`endif
    run_random();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_ctrl.md
# seq_ctrl

Instruction sequencer and decoder for the 8-bit datapath. Fetches 9-bit instructions and drives the ALU's `ALU_op_code`, `Data_op_code` and `Data_signifier` fields. Sequences register-file writes and data-memory transactions through a request/acknowledge handshake. Latches ALU flags for conditional branches and stops on a HALT word.

## Interface
Parameters:
- `PC_W`, 10, program counter / instruction address width
- `TO_CYC`, 16, memory-ack timeout in cycles (used only with the macro in Configuration)

Ports:
- `CLK` in 1: clock, rising edge
- `Reset` in 1: asynchronous, active-high
- `start` in 1: one-cycle pulse; begins execution at PC 0
- `instr_addr` out PC_W: PC to instruction ROM
- `instr_data` in 9: ROM word, combinational from `instr_addr`
- `ALU_op_code` out 3: ALU arithmetic operation
- `Data_op_code` out 2: ALU data operation
- `Data_signifier` out 1: 0 selects an arithmetic op, 1 selects a data op
- `ZERO`, `BEVEN`, `PARITY`, `EQUAL` in 1 each: ALU flags
- `rf_raddr_a`, `rf_raddr_b` out 3: register-file read addresses
- `rf_waddr` out 3: register-file write address
- `rf_we` out 1: register-file write enable
- `wb_sel` out 1: write-back source; 0 = ALU_out, 1 = memory read data
- `mem_req` out 1: memory request; address = read port A, write data = read port B
- `mem_we` out 1: memory write qualifier
- `mem_ack` in 1: memory acknowledge
- `done` out 1: level, asserted in HALT
- `fault` out 1: level, asserted in FAULT (tied to 0 without the macro)

## Operation
Encoding (IR = latched instruction):
- Arithmetic, IR[8]=0:
  - fields: op=IR[7:5], ra=IR[4:2], rb={0,IR[1:0]}
  - ra <= ra op rb
  - kCMP does not write a register
  - kSET writes rb
- Data, IR[8]=1: dop=IR[7:6], rd=IR[5:3], rs=IR[2:0].
  - MOVE: rd <= rs.
  - LOAD: rd <= mem[rs].
  - STORE: mem[rd] <= rs.
  - FLAG acts as the branch instruction: cond=rd, target=LUT[rs].
- Branch conditions:
  - 000 always; 001 Z; 010 !Z; 011 EQ; 100 !EQ; 101 BEVEN; 110 PARITY; 111 never
  - all conditions test the flag register
- 9'h1FF is HALT. It overrides STORE decoding.
- Flag register (4 bits): loaded from the ALU flags in EXEC of every arithmetic instruction. Reset value 0.

FSM states:
- IDLE
  - `start` -> FETCH with PC=0
- FETCH
  - IR <= `instr_data`
  - -> EXEC
- EXEC
  - drives ALU fields and read addresses from IR
  - arithmetic (except CMP) and MOVE: `rf_we`=1, `wb_sel`=0; PC+1 -> FETCH
  - LOAD/STORE: -> MEM
  - branch: PC <= taken ? LUT[rs] : PC+1 -> FETCH
  - HALT -> HALT
- MEM
  - `mem_req`=1 and `mem_we`=(STORE), held stable until `mem_ack`
  - on the ack cycle, LOAD asserts `rf_we`=1, `wb_sel`=1
  - on ack: PC+1 -> FETCH
- HALT
  - `done`=1
  - `start` -> FETCH with PC=0
- FAULT (macro only)
  - `fault`=1
  - left only by `Reset`

Rules:
- PC wraps from 2^PC_W-1 to 0.
- `start` is ignored outside IDLE and HALT.
- `mem_ack` is ignored outside MEM.

## Timing
- Reset values: state IDLE, PC 0, IR 0, flags 0; every output 0.
- `Reset` mid-MEM drops `mem_req` asynchronously and aborts the transaction.
- Non-memory instruction: 2 cycles (FETCH + EXEC).
- Memory instruction: 3 + N cycles, where N is the number of wait cycles before `mem_ack`; an ack in the first MEM cycle gives 3 cycles.
- `rf_we` is a single-cycle pulse per instruction.
- The branch target is visible on `instr_addr` in the cycle after EXEC.
- ALU outputs are decoded combinationally from IR; they are valid throughout EXEC and MEM and held 0 elsewhere.

## Configuration
- `SEQ_MEM_TIMEOUT_EN` defined:
  - a cycle counter runs in MEM
  - if `mem_ack` is still absent after TO_CYC cycles, the sequencer drops `mem_req` and enters FAULT
- Not defined:
  - MEM waits forever
  - no counter is built
  - `fault` is constant 0

## Structure
- Package `definitions`:
  - FSM state enum `seq_state_t`
  - branch condition codes
  - `kHALT` = 9'h1FF
  - field position constants
- Sub-module `branch_lut`:
  - combinational 8-entry table of PC_W-bit targets, indexed by rs
  - contents are a package constant array

## Test plan
- Reset, pulse `start`, ROM[0]=arith kADD ra=1 rb=2 -> `instr_addr`=0 in FETCH; next cycle `ALU_op_code`=kADD, `rf_raddr_a`=1, `rf_raddr_b`=2, `rf_waddr`=1, `rf_we`=1.
- LOAD rd=3 rs=5 with `mem_ack` delayed 4 cycles -> `mem_req` high 5 cycles, `mem_we`=0, `rf_we`/`wb_sel`=1 only on the ack cycle, next fetch at PC+1.
- kCMP with EQUAL=1, then branch cond=011 idx=2 (LUT[2]=40) -> `rf_we`=0 for CMP; taken, `instr_addr`=40. Same sequence with EQUAL=0 -> not taken, PC+1.
- ROM[7]=9'h1FF -> `done`=1 and PC frozen; `start` -> restarts at PC 0, `done`=0.
- `Reset` asserted mid-MEM STORE -> `mem_req` falls without a clock edge; all outputs 0, state IDLE.
- With `SEQ_MEM_TIMEOUT_EN`, no ack -> after 16 cycles `mem_req`=0, `fault`=1, `start` ignored.
